// File: rtl/j_slatchf_pkg.sv
// Shared constants and helpers for the j_slatchf FIFO and its storage word.
package j_slatchf_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 4;

    // Ceiling log2, usable in parameter expressions.
    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/j_slatchw.sv
// One WIDTH-bit storage word: holds, loads on en, clears synchronously on clrl=0.
module j_slatchw #(
    parameter int WIDTH = 16
) (
    input  logic             sys_clk,
    input  logic             resetl,
    input  logic             clrl,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_word;

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            r_word <= '0;
        end else if (!clrl) begin
            r_word <= '0;
        end else if (en) begin
            r_word <= d;
        end
    end

    assign q = r_word;

endmodule

// File: rtl/j_slatchf.sv
// Small first-word-fall-through FIFO with registered head output and sticky
// overflow/underflow flags; storage is DEPTH j_slatchw words.
module j_slatchf
    import j_slatchf_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    localparam int AW    = log2(DEPTH)
) (
    input  logic             sys_clk,
    input  logic             resetl,
    input  logic             clrl,
    input  logic             wr,
    input  logic [WIDTH-1:0] d,
    input  logic             rd,
    output logic [WIDTH-1:0] q,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      cnt,
    output logic             ovf,
    output logic             unf
);

    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_cnt;
    logic             r_ovf;
    logic             r_unf;
    logic [WIDTH-1:0] r_q;

    logic             w_empty;
    logic             w_full;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [AW-1:0]    w_rptr_nxt;
    logic [AW:0]      w_cnt_nxt;
    logic [WIDTH-1:0] w_head;
    logic [DEPTH-1:0] w_wen;
    logic [WIDTH-1:0] w_mem [DEPTH];

    assign w_empty    = (r_cnt == '0);
    assign w_full     = (r_cnt == (AW+1)'(DEPTH));
    assign w_wr_acc   = wr && (!w_full || rd);
    assign w_rd_acc   = rd && !w_empty;
    assign w_rptr_nxt = w_rd_acc ? r_rptr + AW'(1) : r_rptr;

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_cnt_nxt = r_cnt + (AW+1)'(1);
            2'b01:   w_cnt_nxt = r_cnt - (AW+1)'(1);
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // Head after this edge: the word being written bypasses storage when it
    // lands at the new read pointer; an emptied FIFO keeps the last popped word.
    always_comb begin
        w_head = w_mem[w_rptr_nxt];
        if (w_wr_acc && (r_wptr == w_rptr_nxt)) begin
            w_head = d;
        end
        if (w_cnt_nxt == '0) begin
            w_head = r_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            assign w_wen[gi] = w_wr_acc && (r_wptr == AW'(gi));
            j_slatchw #(.WIDTH(WIDTH)) u_word (
                .sys_clk (sys_clk),
                .resetl  (resetl),
                .clrl    (clrl),
                .en      (w_wen[gi]),
                .d       (d),
                .q       (w_mem[gi])
            );
        end
    endgenerate

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            r_q    <= '0;
        end else if (!clrl) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            r_q    <= '0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
            r_rptr <= w_rptr_nxt;
            r_cnt  <= w_cnt_nxt;
            r_q    <= w_head;
            if (wr && w_full && !rd) r_ovf <= 1'b1;
            if (rd && w_empty)       r_unf <= 1'b1;
        end
    end

    assign q     = r_q;
    assign empty = w_empty;
    assign full  = w_full;
    assign cnt   = r_cnt;
    assign ovf   = r_ovf;
    assign unf   = r_unf;

endmodule

// File: tb/tb_j_slatchf.sv
// Directed bench for j_slatchf (WIDTH=16, DEPTH=4) with hand-computed expectations.
module tb_j_slatchf;

    logic        sys_clk;
    logic        resetl;
    logic        clrl;
    logic        wr;
    logic        rd;
    logic [15:0] d;
    logic [15:0] q;
    logic        empty;
    logic        full;
    logic [2:0]  cnt;
    logic        ovf;
    logic        unf;

    int n_cmp = 0;
    int n_err = 0;

    j_slatchf #(.WIDTH(16), .DEPTH(4)) dut (
        .sys_clk (sys_clk),
        .resetl  (resetl),
        .clrl    (clrl),
        .wr      (wr),
        .d       (d),
        .rd      (rd),
        .q       (q),
        .empty   (empty),
        .full    (full),
        .cnt     (cnt),
        .ovf     (ovf),
        .unf     (unf)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push(input logic [15:0] val);
        wr = 1'b1; rd = 1'b0; d = val;
        step();
        wr = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [15:0] exp);
        chk(tag, {16'h0, q}, {16'h0, exp});
        rd = 1'b1; wr = 1'b0;
        step();
        rd = 1'b0;
    endtask

    initial begin
        resetl = 1'b0; clrl = 1'b1; wr = 1'b0; rd = 1'b0; d = '0;
        #2;
        chk("rst_q",     {16'h0, q}, 32'h0);
        chk("rst_empty", {31'h0, empty}, 32'h1);
        chk("rst_full",  {31'h0, full},  32'h0);
        chk("rst_cnt",   {29'h0, cnt},   32'h0);
        chk("rst_flags", {30'h0, ovf, unf}, 32'h0);
        step(); step();
        resetl = 1'b1;
        step();

        // Fill
        push(16'h1111);
        chk("fill_q1",   {16'h0, q}, 32'h1111);
        chk("fill_cnt1", {29'h0, cnt}, 32'h1);
        push(16'h2222);
        push(16'h3333);
        push(16'h4444);
        chk("fill_full", {31'h0, full}, 32'h1);
        chk("fill_cnt4", {29'h0, cnt}, 32'h4);
        chk("fill_qhd",  {16'h0, q}, 32'h1111);

        // Simultaneous read/write while full
        wr = 1'b1; rd = 1'b1; d = 16'h5555;
        step();
        wr = 1'b0; rd = 1'b0;
        chk("rw_full_cnt", {29'h0, cnt}, 32'h4);
        chk("rw_full_ovf", {31'h0, ovf}, 32'h0);
        pop_chk("rw_rd0", 16'h2222);
        pop_chk("rw_rd1", 16'h3333);
        pop_chk("rw_rd2", 16'h4444);
        pop_chk("rw_rd3", 16'h5555);
        chk("drain_empty", {31'h0, empty}, 32'h1);
        chk("empty_hold_q", {16'h0, q}, 32'h5555);

        // Overflow attempt
        push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444);
        push(16'h6666);
        chk("ovf_set", {31'h0, ovf}, 32'h1);
        chk("ovf_cnt", {29'h0, cnt}, 32'h4);
        pop_chk("ovf_rd0", 16'h1111);
        pop_chk("ovf_rd1", 16'h2222);
        pop_chk("ovf_rd2", 16'h3333);
        pop_chk("ovf_rd3", 16'h4444);
        chk("ovf_empty",  {31'h0, empty}, 32'h1);
        chk("ovf_sticky", {31'h0, ovf}, 32'h1);

        // Read while empty with a write
        wr = 1'b1; rd = 1'b1; d = 16'h7777;
        step();
        wr = 1'b0; rd = 1'b0;
        chk("unf_set", {31'h0, unf}, 32'h1);
        chk("unf_cnt", {29'h0, cnt}, 32'h1);
        chk("unf_q",   {16'h0, q}, 32'h7777);
        pop_chk("unf_rd", 16'h7777);
        chk("unf_sticky", {31'h0, unf}, 32'h1);

        // Write/read pairs across pointer wraps
        for (int i = 0; i < 10; i++) begin
            push(16'(i));
            chk($sformatf("pair_q%0d", i), {16'h0, q}, 32'(i));
            chk($sformatf("pair_le1_%0d", i), {31'h0, (cnt <= 3'd1)}, 32'h1);
            rd = 1'b1;
            step();
            rd = 1'b0;
            chk($sformatf("pair_cnt%0d", i), {29'h0, cnt}, 32'h0);
        end

        // Clear overrides a concurrent write
        push(16'hAAAA); push(16'hBBBB); push(16'hCCCC);
        chk("clr_pre_cnt", {29'h0, cnt}, 32'h3);
        clrl = 1'b0; wr = 1'b1; d = 16'hDDDD;
        step();
        clrl = 1'b1; wr = 1'b0;
        chk("clr_cnt",   {29'h0, cnt}, 32'h0);
        chk("clr_empty", {31'h0, empty}, 32'h1);
        chk("clr_q",     {16'h0, q}, 32'h0);
        chk("clr_flags", {30'h0, ovf, unf}, 32'h0);

        // Asynchronous reset mid-cycle
        push(16'h0A0A); push(16'h0B0B); push(16'h0C0C);
        chk("ares_pre_cnt", {29'h0, cnt}, 32'h3);
        #2;
        resetl = 1'b0;
        #1;
        chk("ares_cnt",   {29'h0, cnt}, 32'h0);
        chk("ares_empty", {31'h0, empty}, 32'h1);
        chk("ares_q",     {16'h0, q}, 32'h0);
        chk("ares_full",  {31'h0, full}, 32'h0);
        step();
        resetl = 1'b1;
        push(16'h1234);
        chk("post_rst_q",   {16'h0, q}, 32'h1234);
        chk("post_rst_cnt", {29'h0, cnt}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/j_slatchf.md
J_SLATCHF -- requirements
Module: j_slatchf

Interface
REQ-001 Parameter WIDTH, default 16: data word width in bits, legal 1..32.
REQ-002 Parameter DEPTH, default 4: storage words, power of two, legal 2..16.
REQ-003 Parameter AW, default log2(DEPTH): pointer width, derived, never overridden.
REQ-004 sys_clk  in  1  the only clock; all state changes on its rising edge.
REQ-005 resetl  in  1  asynchronous, active-low reset.
REQ-006 clrl  in  1  synchronous clear, active-low; sampled on sys_clk like any data input.
REQ-007 wr  in  1  write request; d is captured when accepted.
REQ-008 d  in  WIDTH  write data.
REQ-009 rd  in  1  read request; pops the head word when accepted.
REQ-010 q  out  WIDTH  head word, first-word-fall-through, driven from a register.
REQ-011 empty  out  1  high when the occupancy count is 0.
REQ-012 full  out  1  high when the occupancy count equals DEPTH.
REQ-013 cnt  out  AW+1  occupancy, 0..DEPTH.
REQ-014 ovf  out  1  sticky flag: a write was attempted while full without a same-cycle read.
REQ-015 unf  out  1  sticky flag: a read was attempted while empty.

Function
REQ-016 Write acceptance: wr & (!full | rd); an accepted write stores d at the write pointer, and the write pointer increments modulo DEPTH.
REQ-017 Read acceptance: rd & !empty; an accepted read increments the read pointer modulo DEPTH.
REQ-018 cnt: +1 on accepted write only; -1 on accepted read only; unchanged when both or neither are accepted.
REQ-019 Write when full with rd=1: the read and the write are both accepted, cnt stays DEPTH, and ovf does not set.
REQ-020 Read when empty with wr=1: only the write is accepted, unf sets, and cnt becomes 1.
REQ-021 q: the word at the read pointer after each edge; valid one cycle after the write into an empty FIFO (write-to-q latency 1).
REQ-022 q when empty: holds the last popped value; storage is never zeroed except by reset or clear.
REQ-023 Pointer wrap: pointers wrap DEPTH-1 -> 0 silently; full/empty come from cnt, never from pointer compare alone.
REQ-024 ovf/unf: set on the offending cycle and held until reset or clear.
REQ-025 clrl=0 at an edge: pointers, cnt, ovf, unf and storage go to 0, and q goes to 0; clear overrides wr/rd in the same cycle.
REQ-026 empty, full and cnt are registered-state decodes with no combinational path from wr or rd.

Reset
REQ-027 resetl=0 asynchronously forces the read/write pointers, cnt, ovf, unf, every storage word and q to 0, so empty=1 and full=0.
REQ-028 Reset mid-operation discards all contents; the first edge after resetl rises behaves as for an empty FIFO.
REQ-029 Reset deassertion is synchronised externally; the block adds no synchroniser.

Structure
REQ-030 A shared package holds the WIDTH/DEPTH default constants and the log2 helper; nothing block-private goes in it.
REQ-031 One sub-module, j_slatchw, is instantiated DEPTH times.
REQ-032 j_slatchw is a WIDTH-bit enabled, clearable register word with ports sys_clk, resetl, clrl, en, d, q.
REQ-033 j_slatchw holds its value when en=0, loads d when en=1, and clears when clrl=0.
REQ-034 Pointer, count and flag logic lives in j_slatchf; head selection is a DEPTH:1 mux into the q register.

Verification (WIDTH=16, DEPTH=4)
REQ-035 Reset then write 0x1111, 0x2222, 0x3333, 0x4444 -> full=1 and cnt=4 after the 4th edge; q=0x1111 one cycle after the first write.
REQ-036 Full, then wr=1, rd=1, d=0x5555 -> cnt=4, ovf=0; subsequent reads return 0x2222, 0x3333, 0x4444, 0x5555.
REQ-037 Full, then wr=1, rd=0, d=0x6666 -> ovf=1 and contents unchanged; drain 4 words -> empty=1 and ovf still 1.
REQ-038 Empty, then rd=1, wr=1, d=0x7777 -> unf=1, cnt=1, q=0x7777 next cycle.
REQ-039 Run 10 write/read pairs with data 0x0000..0x0009 -> output order preserved across two pointer wraps, cnt never above 1.
REQ-040 With cnt=3, pulse clrl=0 together with wr=1 -> cnt=0, empty=1, q=0.
REQ-041 With cnt=3, assert resetl=0 between edges -> outputs reach reset values immediately, without a clock edge.
